// File: rtl/turn_scheduler.sv
// Per-turn countdown, current-player tracking and random fallback target generator.
// Optional build macro TURN_PAUSE_EN adds a `pause` input that freezes the turn timer.
module turn_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TURN_SEC  = 15,
  parameter int BOARD_N   = 5,
  parameter int MAX_TRIES = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_attack_p1,
  input  logic       en_attack_p2,
  input  logic       en_attack_random,
  input  logic       en_check,
`ifdef TURN_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       target_used,
  output logic [1:0] current_player,
  output logic       timeout,
  output logic [4:0] seconds_left,
  output logic [2:0] rand_row,
  output logic [2:0] rand_col,
  output logic       rand_valid,
  output logic       rand_fail
);

  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0]       SEC_INIT  = 5'(TURN_SEC);
  localparam logic [3:0]       BOARD_LIM = 4'(BOARD_N);
  localparam logic [5:0]       TRY_LIM   = 6'(MAX_TRIES);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUN     = 3'd1;
  localparam logic [2:0] EXPIRED = 3'd2;
  localparam logic [2:0] RANDOM  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]       state, state_n;
  logic [PRE_W-1:0] prescaler, prescaler_n;
  logic [4:0]       seconds_n;
  logic [2:0]       row_n, col_n;
  logic             valid_n, fail_n;
  logic [5:0]       tries, tries_n, tries_inc;
  logic             cand_loaded, cand_loaded_n;
  logic [15:0]      lfsr;
  logic             run_en;
  logic             tick;
  logic             in_range;

`ifdef TURN_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  assign tick      = (prescaler == PRE_LAST) && run_en;
  assign tries_inc = tries + 6'd1;
  // Candidate under test is the one currently presented on rand_row/rand_col.
  assign in_range  = ({1'b0, rand_row} < BOARD_LIM) && ({1'b0, rand_col} < BOARD_LIM);

  always_comb begin
    state_n       = state;
    prescaler_n   = prescaler;
    seconds_n     = seconds_left;
    row_n         = rand_row;
    col_n         = rand_col;
    valid_n       = 1'b0;
    fail_n        = 1'b0;
    tries_n       = tries;
    cand_loaded_n = cand_loaded;

    case (state)
      IDLE: begin
        if (en_attack_p1 || en_attack_p2)
          state_n = RUN;
      end
      RUN: begin
        if (en_check) begin
          state_n = IDLE;
        end else if (run_en) begin
          if (tick) begin
            prescaler_n = '0;
            if (seconds_left == 5'd1) begin
              seconds_n = 5'd0;
              state_n   = EXPIRED;
            end else begin
              seconds_n = seconds_left - 5'd1;
            end
          end else begin
            prescaler_n = prescaler + 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (en_check) begin
          state_n = IDLE;
        end else if (en_attack_random) begin
          state_n       = RANDOM;
          tries_n       = '0;
          cand_loaded_n = 1'b0;
        end
      end
      RANDOM: begin
        if (!cand_loaded) begin
          row_n         = lfsr[2:0];
          col_n         = lfsr[5:3];
          cand_loaded_n = 1'b1;
        end else if (in_range && !target_used) begin
          valid_n = 1'b1;
          state_n = DONE;
        end else if (tries_inc == TRY_LIM) begin
          tries_n       = '0;
          cand_loaded_n = 1'b0;
          fail_n        = 1'b1;
          state_n       = IDLE;
        end else begin
          tries_n = tries_inc;
          row_n   = lfsr[2:0];
          col_n   = lfsr[5:3];
        end
      end
      DONE: begin
        if (en_check)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Every path back to IDLE rearms the timer for the next turn.
    if (state_n == IDLE) begin
      prescaler_n = '0;
      seconds_n   = SEC_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prescaler    <= '0;
      seconds_left <= SEC_INIT;
      rand_row     <= 3'd0;
      rand_col     <= 3'd0;
      rand_valid   <= 1'b0;
      rand_fail    <= 1'b0;
      tries        <= '0;
      cand_loaded  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      prescaler    <= prescaler_n;
      seconds_left <= seconds_n;
      rand_row     <= row_n;
      rand_col     <= col_n;
      rand_valid   <= valid_n;
      rand_fail    <= fail_n;
      tries        <= tries_n;
      cand_loaded  <= cand_loaded_n;
      timeout      <= (state_n == EXPIRED);
    end
  end

  // Player 1 takes precedence if the FSM ever raises both enables together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      current_player <= 2'b00;
    else if (en_attack_p1)
      current_player <= 2'b01;
    else if (en_attack_p2)
      current_player <= 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with TICK_DIV=4, TURN_SEC=3, BOARD_N=5.
module tb_turn_scheduler;

  localparam int TICK_DIV  = 4;
  localparam int TURN_SEC  = 3;
  localparam int BOARD_N   = 5;
  localparam int MAX_TRIES = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_attack_p1 = 1'b0;
  logic       en_attack_p2 = 1'b0;
  logic       en_attack_random = 1'b0;
  logic       en_check = 1'b0;
  logic       target_used = 1'b0;
`ifdef TURN_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [1:0] current_player;
  logic       timeout;
  logic [4:0] seconds_left;
  logic [2:0] rand_row, rand_col;
  logic       rand_valid, rand_fail;

  int tests = 0;
  int failures = 0;

  logic [15:0] lfsr_model;
  logic [15:0] nxt;
  logic [2:0]  cur_row, cur_col;
  logic        accepted, early_fail, valid_seen;
  int          exp_sec;

  turn_scheduler #(
    .TICK_DIV(TICK_DIV), .TURN_SEC(TURN_SEC), .BOARD_N(BOARD_N), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_attack_p1(en_attack_p1),
    .en_attack_p2(en_attack_p2),
    .en_attack_random(en_attack_random),
    .en_check(en_check),
`ifdef TURN_PAUSE_EN
    .pause(pause),
`endif
    .target_used(target_used),
    .current_player(current_player),
    .timeout(timeout),
    .seconds_left(seconds_left),
    .rand_row(rand_row),
    .rand_col(rand_col),
    .rand_valid(rand_valid),
    .rand_fail(rand_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Reference LFSR following the x^16+x^14+x^13+x^11+1 sequence from seed ACE1.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_model <= 16'hACE1;
    else     lfsr_model <= lfsr_step(lfsr_model);
  end

  task automatic applyStimulus(input logic p1, input logic p2, input logic rnd, input logic chk);
    en_attack_p1     = p1;
    en_attack_p2     = p2;
    en_attack_random = rnd;
    en_check         = chk;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runToExpiry(input logic p1, input logic p2);
    applyStimulus(p1, p2, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("expiry_reached", 32'(timeout), 32'd1);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_player",  32'(current_player), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_seconds", 32'(seconds_left), 32'd3);
    checkOutput("rst_lfsr",    32'(dut.lfsr), 32'hACE1);
    rst = 1'b0;
    step();

    // Expiry with player 1 toggling its enable every cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      step();
      applyStimulus((k % 2) == 0, 1'b0, 1'b0, 1'b0);
      exp_sec = (k < 5) ? 3 : (k < 9) ? 2 : (k < 13) ? 1 : 0;
      checkOutput("exp_seconds", 32'(seconds_left), 32'(exp_sec));
      checkOutput("exp_timeout", 32'(timeout), 32'(k >= 13));
      checkOutput("exp_player",  32'(current_player), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("exp_timeout_hold", 32'(timeout), 32'd1);

    // Random accept: first two evaluated candidates are reported as used.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rnd_timeout_drop", 32'(timeout), 32'd0);
    nxt = lfsr_model;
    step();
    cur_row = nxt[2:0];
    cur_col = nxt[5:3];
    checkOutput("rnd_first_row", 32'(rand_row), 32'(cur_row));
    checkOutput("rnd_first_col", 32'(rand_col), 32'(cur_col));
    checkOutput("rnd_first_valid", 32'(rand_valid), 32'd0);
    accepted = 1'b0;
    for (int n = 0; n < MAX_TRIES - 2 && !accepted; n++) begin
      target_used = (n < 2);
      accepted = (cur_row < 3'(BOARD_N)) && (cur_col < 3'(BOARD_N)) && (n >= 2);
      nxt = lfsr_model;
      step();
      checkOutput("rnd_valid", 32'(rand_valid), 32'(accepted));
      if (!accepted) begin
        cur_row = nxt[2:0];
        cur_col = nxt[5:3];
      end
      checkOutput("rnd_row", 32'(rand_row), 32'(cur_row));
      checkOutput("rnd_col", 32'(rand_col), 32'(cur_col));
    end
    target_used = 1'b0;
    checkOutput("rnd_row_range", 32'(rand_row < 3'd5), 32'd1);
    checkOutput("rnd_col_range", 32'(rand_col < 3'd5), 32'd1);
    repeat (3) begin
      step();
      checkOutput("rnd_single_pulse", 32'(rand_valid), 32'd0);
      checkOutput("rnd_hold_row", 32'(rand_row), 32'(cur_row));
      checkOutput("rnd_hold_col", 32'(rand_col), 32'(cur_col));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_exit_seconds", 32'(seconds_left), 32'd3);
    checkOutput("done_exit_row", 32'(rand_row), 32'(cur_row));

    // Player 2 shoots in time at cycle 6.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      applyStimulus(1'b0, (k % 2) == 0, 1'b0, 1'b0);
      checkOutput("shot_timeout", 32'(timeout), 32'd0);
    end
    checkOutput("shot_seconds_ran", 32'(seconds_left), 32'd2);
    checkOutput("shot_player", 32'(current_player), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("shot_seconds_reload", 32'(seconds_left), 32'd3);
    repeat (10) step();
    checkOutput("shot_idle_seconds", 32'(seconds_left), 32'd3);
    checkOutput("shot_idle_timeout", 32'(timeout), 32'd0);

    // Both players together: player 1 wins; en_check beats the expiring tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("both_player", 32'(current_player), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (11) step();
    checkOutput("race_seconds_before", 32'(seconds_left), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("race_timeout", 32'(timeout), 32'd0);
    checkOutput("race_seconds", 32'(seconds_left), 32'd3);
    step();
    checkOutput("race_timeout_later", 32'(timeout), 32'd0);

    // Random fail: every candidate reported as already shot.
    runToExpiry(1'b0, 1'b1);
    target_used = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    early_fail = 1'b0;
    valid_seen = 1'b0;
    for (int i = 1; i <= MAX_TRIES; i++) begin
      step();
      early_fail |= rand_fail;
      valid_seen |= rand_valid;
    end
    checkOutput("fail_not_early", 32'(early_fail), 32'd0);
    step();
    checkOutput("fail_pulse", 32'(rand_fail), 32'd1);
    checkOutput("fail_no_valid", 32'(valid_seen | rand_valid), 32'd0);
    checkOutput("fail_idle_seconds", 32'(seconds_left), 32'd3);
    step();
    checkOutput("fail_one_cycle", 32'(rand_fail), 32'd0);
    target_used = 1'b0;

`ifdef TURN_PAUSE_EN
    // Pause for 20 cycles mid-turn: expiry slips by exactly 20 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    pause = 1'b1;
    repeat (20) step();
    checkOutput("pause_seconds", 32'(seconds_left), 32'd3);
    pause = 1'b0;
    repeat (10) step();
    checkOutput("pause_no_early_timeout", 32'(timeout), 32'd0);
    step();
    checkOutput("pause_timeout", 32'(timeout), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a turn.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("arst_player",  32'(current_player), 32'd0);
    checkOutput("arst_seconds", 32'(seconds_left), 32'd3);
    checkOutput("arst_row",     32'(rand_row), 32'd0);
    checkOutput("arst_col",     32'(rand_col), 32'd0);
    checkOutput("arst_lfsr",    32'(dut.lfsr), 32'hACE1);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("arst_after_seconds", 32'(seconds_left), 32'd3);
    checkOutput("arst_after_timeout", 32'(timeout), 32'd0);
    checkOutput("arst_after_flags", 32'({rand_valid, rand_fail}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
